// File: rtl/branch_pkg.sv
// Shared command encoding and helpers for the branch resolver.
package branch_pkg;

   localparam int unsigned CMD_W = 4;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP   = 4'd0,
      CMD_JUMP  = 4'd1,
      CMD_JAL   = 4'd2,
      CMD_JR    = 4'd3,
      CMD_BEQ   = 4'd4,
      CMD_BNE   = 4'd5,
      CMD_BLT   = 4'd6,
      CMD_BGE   = 4'd7,
      CMD_BLTU  = 4'd8,
      CMD_BGEU  = 4'd9,
      CMD_SLT   = 4'd10,
      CMD_SLTI  = 4'd11,
      CMD_SLTU  = 4'd12,
      CMD_SLTIU = 4'd13
   } cmd_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
   parameter int unsigned WORD_LEN  = 32,
   parameter int unsigned RAS_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic                             pop,
   input  logic [WORD_LEN-1:0]              push_data,
   output logic [WORD_LEN-1:0]              top,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
   output logic                             overflow
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH+1);

   logic [WORD_LEN-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    top_idx;
   logic                full;
   logic                empty;

   // ptr addresses the next free slot; wrapping relies on a power-of-two depth
   assign top_idx = ptr - PTR_W'(1);
   assign top     = mem[top_idx];
   assign full    = (count == CNT_W'(RAS_DEPTH));
   assign empty   = (count == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (full) begin
            overflow <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         ptr   <= top_idx;
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Branch/jump condition resolver with one registered output stage and a return-address stack.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int unsigned WORD_LEN  = 32,
   parameter int unsigned IMM_LEN   = 16,
   parameter int unsigned RAS_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic [CMD_W-1:0]               cmd,
   input  logic [WORD_LEN-1:0]            rs1,
   input  logic [WORD_LEN-1:0]            rs2,
   input  logic [IMM_LEN-1:0]             imm,
   input  logic [WORD_LEN-1:0]            pc,
   input  logic                           stall,
   input  logic                           flush,
   output logic                           out_valid,
   output logic                           br_taken,
   output logic [WORD_LEN-1:0]            target,
   output logic [WORD_LEN-1:0]            link_value,
   output logic                           set_bit,
   output logic                           mispredict,
   output logic                           ras_overflow,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

   logic [WORD_LEN-1:0] imm_ext;
   logic [WORD_LEN-1:0] pc_next;
   logic [WORD_LEN-1:0] br_target;
   logic [WORD_LEN-1:0] ras_top;
   logic                accept;
   logic                ras_push;
   logic                ras_pop;

   logic                taken_n;
   logic                set_n;
   logic                mis_n;
   logic                is_jal;
   logic                is_jr;
   logic [WORD_LEN-1:0] target_n;
   logic [WORD_LEN-1:0] link_n;

   assign imm_ext   = WORD_LEN'($signed(imm));
   assign pc_next   = pc + WORD_LEN'(1);
   assign br_target = pc_next + imm_ext;
   assign accept    = in_valid && !stall && !flush;
   assign ras_push  = accept && is_jal;
   assign ras_pop   = accept && is_jr;

   always_comb begin
      taken_n = 1'b0;
      set_n   = 1'b0;
      mis_n   = 1'b0;
      is_jal  = 1'b0;
      is_jr   = 1'b0;
      case (cmd_e'(cmd))
         CMD_JUMP:  taken_n = 1'b1;
         CMD_JAL: begin
            taken_n = 1'b1;
            is_jal  = 1'b1;
         end
         CMD_JR: begin
            taken_n = 1'b1;
            is_jr   = 1'b1;
            mis_n   = (ras_count == '0) || (ras_top != rs1);
         end
         CMD_BEQ:   taken_n = (rs1 == rs2);
         CMD_BNE:   taken_n = (rs1 != rs2);
         CMD_BLT:   taken_n = ($signed(rs1) <  $signed(rs2));
         CMD_BGE:   taken_n = ($signed(rs1) >= $signed(rs2));
         CMD_BLTU:  taken_n = (rs1 <  rs2);
         CMD_BGEU:  taken_n = (rs1 >= rs2);
         CMD_SLT:   set_n   = ($signed(rs1) < $signed(rs2));
         CMD_SLTU:  set_n   = (rs1 < rs2);
         CMD_SLTI:  set_n   = ($signed(rs1) < $signed(imm_ext));
         CMD_SLTIU: set_n   = (rs1 < imm_ext);
         default: ;
      endcase
      target_n = '0;
      if (taken_n) begin
         target_n = is_jr ? rs1 : br_target;
      end
      link_n = is_jal ? pc_next : '0;
   end

   // flush clears only the flags; target/link keep their last value like an idle cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         br_taken   <= 1'b0;
         target     <= '0;
         link_value <= '0;
         set_bit    <= 1'b0;
         mispredict <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         br_taken   <= 1'b0;
         set_bit    <= 1'b0;
         mispredict <= 1'b0;
      end else if (!stall) begin
         if (in_valid) begin
            out_valid  <= 1'b1;
            br_taken   <= taken_n;
            target     <= target_n;
            link_value <= link_n;
            set_bit    <= set_n;
            mispredict <= mis_n;
         end else begin
            out_valid  <= 1'b0;
         end
      end
   end

   ras_stack #(
      .WORD_LEN  (WORD_LEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_next),
      .top       (ras_top),
      .count     (ras_count),
      .overflow  (ras_overflow)
   );

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter WORD_LEN, default 32, SHALL set the data and PC width in bits.
REQ-002 Parameter IMM_LEN, default 16, SHALL set the immediate width in bits.
REQ-003 Parameter RAS_DEPTH, default 8, SHALL set the return-address-stack entry count (power of two, at least 2).
REQ-004 Port clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous assertion, active-low.
REQ-006 Ports SHALL be:
- in_valid  in  1: request valid.
- cmd  in  4: command code (package enum).
- rs1, rs2  in  WORD_LEN: operands.
- imm  in  IMM_LEN: signed offset / immediate.
- pc  in  WORD_LEN: word-addressed PC of the instruction.
- stall  in  1: hold all state.
- flush  in  1: kill the current request and the output.
- out_valid  out  1: result valid.
- br_taken  out  1: redirect PC.
- target  out  WORD_LEN: redirect address.
- link_value  out  WORD_LEN: pc+1 for JAL, else 0.
- set_bit  out  1: SLT-family result.
- mispredict  out  1: JR target differs from RAS prediction.
- ras_overflow  out  1: sticky; an entry was overwritten.
- ras_count  out  clog2(RAS_DEPTH+1): occupancy.

Function
REQ-007 Latency SHALL be exactly one cycle: a request accepted at edge N SHALL appear on the outputs after edge N, held until the next accepted request or flush.
REQ-008 Acceptance SHALL occur when in_valid=1, stall=0 and flush=0.
REQ-009 When stall=1 and flush=0, all outputs, the RAS and ras_count SHALL hold.
REQ-010 flush=1 SHALL clear out_valid, br_taken, set_bit and mispredict at the next edge, SHALL leave the RAS untouched, and SHALL take priority over stall and in_valid.
REQ-011 When no request is accepted and there is no flush or stall, out_valid SHALL be 0 after the edge and the other outputs SHALL hold.
REQ-012 Branch target SHALL be pc + 1 + sign-extended imm, computed modulo 2^WORD_LEN.
REQ-013 Commands:
- JUMP: taken.
- JAL: taken, with link_value = pc+1 and a RAS push of pc+1.
- JR: taken, with target = rs1, a RAS pop, and mispredict = (count==0) or (top != rs1).
- BEQ / BNE: equal / not-equal.
- BLT / BGE: signed compare.
- BLTU / BGEU: unsigned compare.
- SLT / SLTU: set_bit = rs1 < rs2, signed / unsigned, not taken.
- SLTI / SLTIU: set_bit = rs1 < sign-extended imm, signed / unsigned, not taken.
- NOP and undefined codes: all flags 0.
REQ-014 For every non-taken result, target SHALL be 0.
REQ-015 RAS push when full SHALL overwrite the oldest entry (circular), keep ras_count at RAS_DEPTH and set ras_overflow.
REQ-016 RAS pop when empty SHALL leave ras_count at 0, leave the pointer unchanged and assert mispredict.
REQ-017 mispredict SHALL be 0 for all commands other than JR.
REQ-018 ras_overflow SHALL clear only on reset.

Reset
REQ-019 rst_n=0 SHALL immediately force to 0, independent of clk: out_valid, br_taken, target, link_value, set_bit, mispredict, ras_overflow, ras_count and the RAS pointer. RAS entry contents need not be reset.
REQ-020 A request in flight when reset asserts SHALL be discarded. The first acceptance SHALL occur at the first rising edge with rst_n=1.

Structure
REQ-021 The cmd enum (4 bits: NOP, JUMP, JAL, JR, BEQ, BNE, BLT, BGE, BLTU, BGEU, SLT, SLTI, SLTU, SLTIU) SHALL live in shared package branch_pkg.
REQ-022 The return-address stack SHALL be a sub-module ras_stack, parametrised by WORD_LEN and RAS_DEPTH, with push/pop/top/count/overflow ports. Condition evaluation SHALL be combinational logic feeding one output register stage.

Verification
REQ-023 BEQ with rs1=5, rs2=5, pc=0x10, imm=-4 -> br_taken=1, target=0x0D one cycle later. Same inputs with BNE -> br_taken=0, target=0.
REQ-024 BLT with rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken. SLTIU with rs1=3, imm=0xFFFF -> set_bit=1.
REQ-025 JAL at pc=0x20 -> link_value=0x21, ras_count=1. Then JR with rs1=0x21 -> mispredict=0, ras_count=0. Then JR with rs1=0x40 -> mispredict=1, ras_count=0.
REQ-026 Nine JALs with RAS_DEPTH=8 -> ras_count=8, ras_overflow=1. Eight JR pops -> predictions are the newest 8 return addresses, in LIFO order.
REQ-027 JAL with stall=1 -> no push and outputs held. JAL with stall=1 and flush=1 -> out_valid=0 and no push.
REQ-028 rst_n pulsed low mid-stream (asynchronously, between edges) -> all outputs and ras_count read 0 before the next edge.
